// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decodes a fetched word into ID/EX control fields and
// holds them in a one-entry registered slot with valid/ready on both sides.
module rv_decode_stage #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic [3:0]       out_alu_op,
    output logic             out_alu_src,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_jalr,
    output logic             out_lui,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            lui;
        logic            illegal;
    } slot_t;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3,
                                           input logic       alt);
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic [31:0] imm_sh;
    logic        is_shift;

    assign opc      = in_instr[6:0];
    assign rd_f     = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign rs1_f    = in_instr[19:15];
    assign rs2_f    = in_instr[24:20];
    assign f7       = in_instr[31:25];
    assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u    = {in_instr[31:12], 12'b0};
    assign imm_sh   = {27'b0, in_instr[24:20]};
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    slot_t dec;
    logic  legal;
    logic  wr;

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        legal     = 1'b0;
        wr        = 1'b0;
        unique case (opc)
            OP_R: begin
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                dec.rd     = rd_f;
                dec.rs1    = rs1_f;
                dec.rs2    = rs2_f;
                dec.alu_op = alu_sel(f3, f7 == F7_ALT);
                wr         = 1'b1;
            end
            OP_IALU: begin
                unique case (f3)
                    3'b001:  legal = (f7 == F7_BASE);
                    3'b101:  legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
                dec.rd      = rd_f;
                dec.rs1     = rs1_f;
                dec.imm     = is_shift ? imm_sh : imm_i;
                // funct7 only selects SRA for shift-right; for ADDI it is imm.
                dec.alu_op  = alu_sel(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                dec.alu_src = 1'b1;
                wr          = 1'b1;
            end
            OP_LOAD: begin
                legal        = (f3 == 3'b010);
                dec.rd       = rd_f;
                dec.rs1      = rs1_f;
                dec.imm      = imm_i;
                dec.alu_src  = 1'b1;
                dec.mem_read = 1'b1;
                wr           = 1'b1;
            end
            OP_STORE: begin
                legal         = (f3 == 3'b010);
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.imm       = imm_s;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                legal      = (f3 == 3'b000);
                dec.rs1    = rs1_f;
                dec.rs2    = rs2_f;
                dec.imm    = imm_b;
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
            end
            OP_JAL: begin
                legal       = 1'b1;
                dec.rd      = rd_f;
                dec.imm     = imm_j;
                dec.alu_src = 1'b1;
                dec.jump    = 1'b1;
                wr          = 1'b1;
            end
            OP_JALR: begin
                legal       = (f3 == 3'b000);
                dec.rd      = rd_f;
                dec.rs1     = rs1_f;
                dec.imm     = imm_i;
                dec.alu_src = 1'b1;
                dec.jump    = 1'b1;
                dec.jalr    = 1'b1;
                wr          = 1'b1;
            end
            OP_LUI: begin
                legal       = 1'b1;
                dec.rd      = rd_f;
                dec.imm     = imm_u;
                dec.alu_src = 1'b1;
                dec.lui     = 1'b1;
                wr          = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end else begin
            dec.reg_write = wr && (rd_f != 5'd0);
        end
    end

    slot_t            slot_q, slot_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            slot_d  = dec;
            valid_d = 1'b1;
            if (dec.illegal && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = slot_q.pc;
    assign out_rd        = slot_q.rd;
    assign out_rs1       = slot_q.rs1;
    assign out_rs2       = slot_q.rs2;
    assign out_imm       = slot_q.imm;
    assign out_alu_op    = slot_q.alu_op;
    assign out_alu_src   = slot_q.alu_src;
    assign out_reg_write = slot_q.reg_write;
    assign out_mem_read  = slot_q.mem_read;
    assign out_mem_write = slot_q.mem_write;
    assign out_branch    = slot_q.branch;
    assign out_jump      = slot_q.jump;
    assign out_jalr      = slot_q.jalr;
    assign out_lui       = slot_q.lui;
    assign out_illegal   = slot_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed literal cases plus randomized traffic
// checked every cycle against a behavioural decode/handshake model.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_op;
    logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch, out_jump, out_jalr, out_lui, out_illegal;
    logic [15:0] illegal_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rv_decode_stage #(.PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_alu_op(out_alu_op),
        .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_jalr(out_jalr),
        .out_lui(out_lui), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src, rw, mr, mw, br, jmp, jalr, lui, ill;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] w,
                                     input logic [31:0] pc);
        exp_t e;
        logic ok;
        logic wr;
        int ops[8];
        logic [6:0] f7;
        logic [2:0] f3;
        logic [31:0] ii;
        ops = '{0, 2, 3, 4, 5, 6, 8, 9};
        f7 = w[31:25];
        f3 = w[14:12];
        ii = {{20{w[31]}}, w[31:20]};
        e = '0;
        e.pc = pc;
        ok = 1'b0;
        wr = 1'b0;
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) ||
                     (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.alu = 4'(ops[f3] + ((f7 == 7'h20) ? 1 : 0));
                wr = 1'b1;
            end
            7'h13: begin
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
                else ok = 1'b1;
                e.rd = w[11:7]; e.rs1 = w[19:15];
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, w[24:20]} : ii;
                e.alu = 4'(ops[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 1 : 0));
                e.src = 1'b1; wr = 1'b1;
            end
            7'h03: begin
                ok = (f3 == 3'd2);
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = ii;
                e.src = 1'b1; e.mr = 1'b1; wr = 1'b1;
            end
            7'h23: begin
                ok = (f3 == 3'd2);
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                e.src = 1'b1; e.mw = 1'b1;
            end
            7'h63: begin
                ok = (f3 == 3'd0);
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                e.alu = 4'd1; e.br = 1'b1;
            end
            7'h6F: begin
                ok = 1'b1;
                e.rd = w[11:7];
                e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                e.src = 1'b1; e.jmp = 1'b1; wr = 1'b1;
            end
            7'h67: begin
                ok = (f3 == 3'd0);
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = ii;
                e.src = 1'b1; e.jmp = 1'b1; e.jalr = 1'b1; wr = 1'b1;
            end
            7'h37: begin
                ok = 1'b1;
                e.rd = w[11:7]; e.imm = {w[31:12], 12'b0};
                e.src = 1'b1; e.lui = 1'b1; wr = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            e.pc = pc;
            e.ill = 1'b1;
        end else begin
            e.rw = wr && (e.rd != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: begin
                w[6:0] = 7'h33;
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
                if (w[31:25] == 7'h20)
                    w[14:12] = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'd5;
            end
            1: w[6:0] = 7'h33;
            2: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1)
                    w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
            end
            3: begin
                w[6:0] = 7'h03;
                if ($urandom_range(0, 1) == 1) w[14:12] = 3'd2;
            end
            4: begin
                w[6:0] = 7'h23;
                if ($urandom_range(0, 1) == 1) w[14:12] = 3'd2;
            end
            5: begin
                w[6:0] = 7'h63;
                if ($urandom_range(0, 1) == 1) w[14:12] = 3'd0;
            end
            6: w[6:0] = 7'h6F;
            7: begin
                w[6:0] = 7'h67;
                if ($urandom_range(0, 1) == 1) w[14:12] = 3'd0;
            end
            8: w[6:0] = 7'h37;
            default: ;
        endcase
        return w;
    endfunction

    exp_t        nx;
    exp_t        m;
    logic        m_valid;
    logic [15:0] m_cnt;

    always_comb nx = ref_dec(in_instr, in_pc);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m <= '0;
            m_cnt <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m <= nx;
            if (nx.ill && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid", 32'(out_valid), 32'(m_valid));
            chk("cmp_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("cmp_count", 32'(illegal_count), 32'(m_cnt));
            if (m_valid || !reset_n) begin
                chk("cmp_pc", out_pc, m.pc);
                chk("cmp_rd", 32'(out_rd), 32'(m.rd));
                chk("cmp_rs1", 32'(out_rs1), 32'(m.rs1));
                chk("cmp_rs2", 32'(out_rs2), 32'(m.rs2));
                chk("cmp_imm", out_imm, m.imm);
                chk("cmp_alu", 32'(out_alu_op), 32'(m.alu));
                chk("cmp_flags",
                    32'({out_alu_src, out_reg_write, out_mem_read,
                         out_mem_write, out_branch, out_jump, out_jalr,
                         out_lui, out_illegal}),
                    32'({m.src, m.rw, m.mr, m.mw, m.br, m.jmp, m.jalr,
                         m.lui, m.ill}));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue1(input logic [31:0] w, input logic [31:0] pc);
        in_instr = w;
        in_pc = pc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(illegal_count), 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        cyc();
        reset_n = 1'b1;

        issue1(32'h002081B3, 32'h100);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_regs", 32'({out_rd, out_rs1, out_rs2}),
            32'({5'd3, 5'd1, 5'd2}));
        chk("add_alu", 32'({out_alu_op, out_alu_src, out_reg_write}),
            32'({4'd0, 1'b0, 1'b1}));
        chk("add_imm", out_imm, 32'd0);
        chk("add_pc", out_pc, 32'h100);

        issue1(32'hFFF00293, 32'h104);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_ctl", 32'({out_alu_src, out_rd, out_reg_write}),
            32'({1'b1, 5'd5, 1'b1}));

        issue1(32'h0020A423, 32'h108);
        chk("sw_ctl", 32'({out_mem_write, out_reg_write}), 32'b10);
        chk("sw_imm", out_imm, 32'd8);

        issue1(32'hFE208EE3, 32'h10C);
        chk("beq_ctl", 32'({out_branch, out_alu_op}), 32'({1'b1, 4'd1}));
        chk("beq_imm", out_imm, 32'hFFFFFFFC);

        issue1(32'h00000000, 32'h110);
        chk("ill0_flag", 32'(out_illegal), 32'd1);
        chk("ill0_count", 32'(illegal_count), 32'd1);
        issue1(32'h40209033, 32'h114);
        chk("ill1_flag", 32'(out_illegal), 32'd1);
        chk("ill1_count", 32'(illegal_count), 32'd2);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00A00513;
        in_pc = 32'h118;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) begin
            cyc();
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", {out_illegal, out_pc[30:0]}, {1'b1, 31'h114});
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        #1;
        chk("b2b_first", 32'({out_valid, out_rd, out_imm[7:0]}),
            32'({1'b1, 5'd10, 8'd10}));
        in_instr = 32'h00B00593;
        in_pc = 32'h11C;
        cyc();
        #1;
        chk("b2b_second", 32'({out_valid, out_rd}), 32'({1'b1, 5'd11}));

        out_ready = 1'b0;
        in_instr = 32'h00000000;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(illegal_count), 32'd2);

        issue1(32'h00000000, 32'h120);
        chk("pre_rst_count", 32'(illegal_count), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(illegal_count), 32'd0);
        cyc();
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            in_instr = gen();
            in_pc = $urandom;
            cyc();
        end

        flush = 1'b0;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_instr = 32'h00000000;
        repeat (65540) cyc();
        #1;
        chk("sat_count", 32'(illegal_count), 32'h0000FFFF);
        in_valid = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
